// File: rtl/mgt_null_rx_checker.sv
// mgt_null_rx_checker
//   RX-side checker for the MGT null-pair test stream. It runs on one lane's
//   parallel RX interface and acquires frame lock on the comma word. Every
//   word is then checked against the expected frame content. Link status and
//   error statistics are reported.
//
//   Frame layout: one comma word (COMMA_WORD with COMMA_K), followed by
//   FRAME_LEN-1 data words 0, 1, ..., FRAME_LEN-2. Data words have charisk=0.
//
// Ports
//   clk            lane reference clock
//   rst_n          asynchronous active-low reset
//   rx_valid       current RX word is valid; invalid cycles are ignored
//   rx_data        parallel RX word
//   rx_charisk     per-byte K flags
//   rx_disperr     per-byte disparity error
//   rx_notintable  per-byte invalid code
//   err_clr        synchronous clear of err_count
//   link_up        high while LOCKED
//   word_err       one-cycle pulse per errored word while LOCKED
//   err_count      saturating errored-word count (LOCKED only)
//   lock_state     0=HUNT, 1=VERIFY, 2=LOCKED
module mgt_null_rx_checker #(
  parameter int          FRAME_LEN     = 8,
  parameter logic [15:0] COMMA_WORD    = 16'hBC50,
  parameter logic [1:0]  COMMA_K       = 2'b10,
  parameter int          LOCK_FRAMES   = 4,
  parameter int          UNLOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_charisk,
  input  logic [1:0]  rx_disperr,
  input  logic [1:0]  rx_notintable,
  input  logic        err_clr,
  output logic        link_up,
  output logic        word_err,
  output logic [15:0] err_count,
  output logic [1:0]  lock_state
);

  localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;
  localparam int BW = (UNLOCK_FRAMES > 1) ? $clog2(UNLOCK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [GW-1:0]     good_q, good_d;
  logic [BW-1:0]     bad_q, bad_d;
  logic              ferr_q, ferr_d;
  logic              link_up_q, link_up_d;
  logic              word_err_q, word_err_d;
  logic [15:0]       err_count_q, err_count_d;

  // Word classification against the current frame position.
  logic          code_err, is_comma, data_ok, exp_ok, last_pos, frame_err;
  logic [PW-1:0] pos_nxt;

  assign code_err = (|rx_disperr) | (|rx_notintable);
  assign is_comma = (rx_data == COMMA_WORD) && (rx_charisk == COMMA_K) && !code_err;
  assign data_ok  = (rx_data == (16'(pos_q) - 16'd1)) && (rx_charisk == 2'b00) && !code_err;
  // A comma at a data position fails data_ok because its charisk is non-zero.
  assign exp_ok   = (pos_q == '0) ? is_comma : data_ok;
  assign last_pos = (pos_q == PW'(FRAME_LEN - 1));
  assign pos_nxt  = last_pos ? '0 : pos_q + PW'(1);
  // The frame verdict includes the error of the last word itself.
  assign frame_err = ferr_q | ~exp_ok;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    bad_d       = bad_q;
    ferr_d      = ferr_q;
    word_err_d  = 1'b0;
    err_count_d = err_count_q;

    if (rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_comma) begin
            pos_d  = PW'(1);
            good_d = GW'(1);
            if (LOCK_FRAMES == 1) begin
              state_d = LOCKED;
              bad_d   = '0;
              ferr_d  = 1'b0;
            end else begin
              state_d = VERIFY;
            end
          end
        end

        VERIFY: begin
          if (!exp_ok) begin
            state_d = HUNT;
            pos_d   = '0;
            good_d  = '0;
          end else begin
            pos_d = pos_nxt;
            if (pos_q == '0) begin
              good_d = good_q + GW'(1);
              if (good_q == GW'(LOCK_FRAMES - 1)) begin
                state_d = LOCKED;
                bad_d   = '0;
                ferr_d  = 1'b0;
              end
            end
          end
        end

        LOCKED: begin
          pos_d = pos_nxt;
          if (!exp_ok) begin
            word_err_d = 1'b1;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
          if (last_pos) begin
            ferr_d = 1'b0;
            if (frame_err) begin
              bad_d = bad_q + BW'(1);
              if (bad_q == BW'(UNLOCK_FRAMES - 1)) begin
                state_d = HUNT;
                pos_d   = '0;
                good_d  = '0;
                bad_d   = '0;
              end
            end else begin
              bad_d = '0;
            end
          end else begin
            ferr_d = frame_err;
          end
        end

        default: begin
          state_d = HUNT;
          pos_d   = '0;
          good_d  = '0;
          bad_d   = '0;
          ferr_d  = 1'b0;
        end
      endcase
    end

    // The clear wins over a same-cycle increment; word_err still pulses.
    if (err_clr) err_count_d = '0;

    link_up_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      pos_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      ferr_q      <= 1'b0;
      link_up_q   <= 1'b0;
      word_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ferr_q      <= ferr_d;
      link_up_q   <= link_up_d;
      word_err_q  <= word_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign link_up    = link_up_q;
  assign word_err   = word_err_q;
  assign err_count  = err_count_q;
  assign lock_state = state_q;

endmodule

// File: tb/tb_mgt_null_rx_checker.sv
module tb_mgt_null_rx_checker;

  localparam logic [15:0] COMMA = 16'hBC50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic [1:0]  rx_charisk = '0;
  logic [1:0]  rx_disperr = '0;
  logic [1:0]  rx_notintable = '0;
  logic        err_clr = 1'b0;
  logic        link_up, word_err;
  logic [15:0] err_count;
  logic [1:0]  lock_state;

  always #5 clk = ~clk;

  mgt_null_rx_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_charisk    (rx_charisk),
    .rx_disperr    (rx_disperr),
    .rx_notintable (rx_notintable),
    .err_clr       (err_clr),
    .link_up       (link_up),
    .word_err      (word_err),
    .err_count     (err_count),
    .lock_state    (lock_state)
  );

  typedef struct packed {
    logic        link;
    logic        werr;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t sbq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state (FRAME_LEN=8, LOCK_FRAMES=4, UNLOCK_FRAMES=2)
  int          m_st = 0, m_pos = 0, m_good = 0, m_bad = 0;
  bit          m_ferr = 0;
  logic [15:0] m_cnt = '0;

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_good = 0; m_bad = 0; m_ferr = 0; m_cnt = '0;
    sbq.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its outcome into the scoreboard, then compare.
  task automatic step(input logic v, input logic [15:0] d, input logic [1:0] k,
                      input logic [1:0] de, input logic [1:0] ni, input logic clr);
    bit   code, comma, ok, fe;
    logic werr;
    exp_t e;
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_charisk = k; rx_disperr = de;
    rx_notintable = ni; err_clr = clr;
    werr  = 1'b0;
    code  = (de != 0) || (ni != 0);
    comma = (d == COMMA) && (k == 2'b10) && !code;
    if (v) begin
      ok = (m_pos == 0) ? comma : ((d == 16'(m_pos - 1)) && (k == 2'b00) && !code);
      case (m_st)
        0: if (comma) begin m_st = 1; m_good = 1; m_pos = 1; end
        1: begin
          if (!ok) begin m_st = 0; m_good = 0; m_pos = 0; end
          else begin
            if (m_pos == 0) begin
              m_good++;
              if (m_good == 4) begin m_st = 2; m_bad = 0; m_ferr = 0; end
            end
            m_pos = (m_pos + 1) % 8;
          end
        end
        default: begin
          fe = m_ferr || !ok;
          if (!ok) begin
            werr = 1'b1;
            if (!clr && m_cnt != 16'hFFFF) m_cnt++;
          end
          if (m_pos == 7) begin
            m_bad  = fe ? m_bad + 1 : 0;
            m_ferr = 0;
            m_pos  = 0;
            if (m_bad == 2) begin m_st = 0; m_bad = 0; m_good = 0; end
          end else begin
            m_ferr = fe;
            m_pos++;
          end
        end
      endcase
    end
    if (clr) m_cnt = '0;
    sbq.push_back('{link: (m_st == 2), werr: werr, cnt: m_cnt, st: 2'(m_st)});
    @(posedge clk); #1;
    e = sbq.pop_front();
    check("link_up", 32'(link_up), 32'(e.link));
    check("word_err", 32'(word_err), 32'(e.werr));
    check("err_count", 32'(err_count), 32'(e.cnt));
    check("lock_state", 32'(lock_state), 32'(e.st));
  endtask

  task automatic sw(input int p);
    if (p == 0) step(1'b1, COMMA, 2'b10, 2'b00, 2'b00, 1'b0);
    else        step(1'b1, 16'(p - 1), 2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic bad(input logic [15:0] d);
    step(1'b1, d, 2'b00, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++)
      for (int p = 0; p < 8; p++) sw(p);
  endtask

  task automatic gap();
    step(1'b0, 16'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_link"}, 32'(link_up), 32'd0);
    check({tag, "_werr"}, 32'(word_err), 32'd0);
    check({tag, "_cnt"}, 32'(err_count), 32'd0);
    check({tag, "_state"}, 32'(lock_state), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk); #2;
    rst_n = 1'b0; rx_valid = 1'b0; err_clr = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [15:0] saved_cnt;

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    // 1: enter mid-frame at data word 0x0003, lock on 4th comma
    for (int p = 4; p < 8; p++) sw(p);
    check("t1_hunt_before_comma", 32'(lock_state), 32'd0);
    frames(3);
    check("t1_link_before_w24", 32'(link_up), 32'd0);
    sw(0);
    check("t1_link_after_w24", 32'(link_up), 32'd1);
    for (int p = 1; p < 8; p++) sw(p);
    frames(2);
    check("t1_cnt_clean", 32'(err_count), 32'd0);

    // 2: single data error, then two errors in one frame
    sw(0); sw(1); sw(2); bad(16'h0006);
    check("t2_werr", 32'(word_err), 32'd1);
    check("t2_cnt1", 32'(err_count), 32'd1);
    for (int p = 4; p < 8; p++) sw(p);
    check("t2_link", 32'(link_up), 32'd1);
    frames(1);
    step(1'b1, COMMA, 2'b10, 2'b00, 2'b00, 1'b1);
    check("t2_clr", 32'(err_count), 32'd0);
    sw(1); bad(16'h0009); bad(16'h0007);
    check("t2_cnt2", 32'(err_count), 32'd2);
    for (int p = 4; p < 8; p++) sw(p);
    check("t2_link_two_err", 32'(link_up), 32'd1);
    frames(1);

    // 3: errored frames separated by a clean frame keep lock; two in a row drop it
    for (int p = 0; p < 5; p++) sw(p);
    bad(16'h0F00); sw(6); sw(7);
    frames(1);
    for (int p = 0; p < 5; p++) sw(p);
    bad(16'h0F00); sw(6); sw(7);
    check("t3_link_kept", 32'(link_up), 32'd1);
    frames(1);
    sw(0); bad(16'hAAAA);
    for (int p = 2; p < 8; p++) sw(p);
    sw(0); sw(1); bad(16'h5555);
    for (int p = 3; p < 7; p++) sw(p);
    check("t3_link_before_last", 32'(link_up), 32'd1);
    sw(7);
    check("t3_link_dropped", 32'(link_up), 32'd0);
    check("t3_state_hunt", 32'(lock_state), 32'd0);

    // 4: disparity error in VERIFY returns to HUNT
    saved_cnt = err_count;
    frames(1);
    sw(0); sw(1); sw(2); sw(3);
    check("t4_verify", 32'(lock_state), 32'd1);
    step(1'b1, 16'h0003, 2'b00, 2'b01, 2'b00, 1'b0);
    check("t4_hunt", 32'(lock_state), 32'd0);
    check("t4_cnt_held", 32'(err_count), 32'(saved_cnt));
    for (int p = 5; p < 8; p++) sw(p);
    frames(3);
    check("t4_link_before", 32'(link_up), 32'd0);
    sw(0);
    check("t4_relock", 32'(link_up), 32'd1);
    for (int p = 1; p < 8; p++) sw(p);

    // 5: saturation and clear priority
    @(negedge clk);
    rx_valid = 1'b0;
    force dut.err_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_count_q;
    m_cnt = 16'hFFFE;
    check("t5_forced", 32'(err_count), 32'hFFFE);
    sw(0); bad(16'h1111); bad(16'h2222); bad(16'h3333);
    check("t5_sat", 32'(err_count), 32'hFFFF);
    for (int p = 4; p < 8; p++) sw(p);
    frames(1);
    sw(0);
    step(1'b1, 16'h1234, 2'b00, 2'b00, 2'b00, 1'b1);
    check("t5_clr_cnt", 32'(err_count), 32'd0);
    check("t5_clr_werr", 32'(word_err), 32'd1);
    for (int p = 2; p < 8; p++) sw(p);

    // 6: reset mid-LOCKED, relock through random valid gaps
    async_reset("t6_rst1");
    for (int w = 0; w < 25; w++) begin
      if ($urandom_range(0, 2) == 0) gap();
      if (w == 24) check("t6_gap_link_before", 32'(link_up), 32'd0);
      sw(w % 8);
    end
    check("t6_gap_link", 32'(link_up), 32'd1);
    for (int w = 1; w < 24; w++) begin
      if ($urandom_range(0, 1) == 0) gap();
      sw(w % 8);
    end
    check("t6_gap_cnt", 32'(err_count), 32'd0);
    async_reset("t6_rst2");
    frames(3);
    check("t6_relock_before", 32'(link_up), 32'd0);
    sw(0);
    check("t6_relock", 32'(link_up), 32'd1);

    @(negedge clk); rx_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mgt_null_rx_checker.md
Name: mgt_null_rx_checker

Overview:
- Receive-side companion to the MGT null-pair pattern generator.
- Sits on the parallel RX side of one MGT lane, clocked by the lane's reference clock.
- Acquires frame lock on the null test stream, checks every word against the expected pattern, and reports link status plus error statistics.
- One instance per MGT lane, enabled per lane by the MGT null controller.

Parameters:
- FRAME_LEN, 8, words per frame: 1 comma word followed by FRAME_LEN-1 data words (minimum 2).
- COMMA_WORD, 16'hBC50, value of the frame-start comma word.
- COMMA_K, 2'b10, charisk value that accompanies COMMA_WORD.
- LOCK_FRAMES, 4, consecutive valid commas at correct spacing needed to declare lock.
- UNLOCK_FRAMES, 2, consecutive errored frames in LOCKED that cause loss of lock.

Ports:
- clk  in  1  lane reference clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  current rx word is valid; words are ignored when low.
- rx_data  in  16  parallel RX word.
- rx_charisk  in  2  per-byte K flags.
- rx_disperr  in  2  per-byte disparity error.
- rx_notintable  in  2  per-byte invalid code.
- err_clr  in  1  synchronous clear of err_count.
- link_up  out  1  high while in LOCKED.
- word_err  out  1  one-cycle pulse per errored word while LOCKED.
- err_count  out  16  saturating count of errored words while LOCKED.
- lock_state  out  2  current state: 0=HUNT, 1=VERIFY, 2=LOCKED.

Behaviour:
- Reset values: link_up=0, word_err=0, err_count=0, lock_state=HUNT. Internal counters (pos, good_cnt, bad_frames, frame-error flag) also reset to 0.
- Only words with rx_valid=1 are processed. Internal state holds when rx_valid=0, and word_err is 0 on that cycle.
- All outputs are registered: the effect of a word appears 1 cycle after it is sampled.
- A word is a code error if any rx_disperr or rx_notintable bit is set.
- A word is a comma if rx_data==COMMA_WORD, rx_charisk==COMMA_K, and it is not a code error.
- Expected word at position pos:
  - pos=0: a comma.
  - pos=k (1..FRAME_LEN-1): rx_data==k-1 (16-bit) with rx_charisk=0 and no code error.
- A word is errored if it differs from the expected word at its position, including an unexpected comma at pos!=0.
- pos advances modulo FRAME_LEN on every processed word in VERIFY and LOCKED. pos is not realigned on a mid-frame comma.
- HUNT:
  - On a comma: go to VERIFY with good_cnt=1 and pos=1.
  - Any other word: stay in HUNT.
- VERIFY:
  - Any errored word: go to HUNT, good_cnt=0.
  - A valid comma at pos=0: good_cnt+1. When good_cnt reaches LOCK_FRAMES, go to LOCKED with bad_frames=0.
  - If LOCK_FRAMES=1, go directly HUNT->LOCKED on the first comma.
- LOCKED:
  - Each errored word pulses word_err, increments err_count (saturating at 16'hFFFF), and sets the frame-error flag.
  - When the word at pos=FRAME_LEN-1 is processed, include that word's own error in the frame-error flag, then:
    - errored frame: bad_frames+1;
    - clean frame: bad_frames=0.
    - Clear the flag.
  - When bad_frames reaches UNLOCK_FRAMES, go to HUNT and drop link_up on the next cycle.
- err_clr:
  - Clears err_count to 0 on the next edge.
  - Has priority over a simultaneous increment; that error is not counted.
  - word_err still pulses for that error.
- err_count holds its value when the block leaves LOCKED. Only reset or err_clr clears it.
- Reset asserted mid-operation clears everything asynchronously. After release, the block re-hunts from HUNT.

Test Plan (FRAME_LEN=8, LOCK_FRAMES=4, UNLOCK_FRAMES=2):
1. Clean stream entered mid-frame at data word 0x0003 → lock_state stays HUNT until the first comma.
   - First comma = word 0; link_up=1 the cycle after word 24 (4th comma).
   - Thereafter word_err=0 and err_count=0.
2. While LOCKED, replace one data word 0x0002 with 0x0006 → one word_err pulse, err_count=1, link_up stays 1.
   - With 2 errors in one frame, err_count=2 and bad_frames=1 only.
3. While LOCKED, corrupt one word in each of two consecutive frames → link_up=0 the cycle after the last word of the second frame, lock_state=HUNT.
   - A clean frame in between resets bad_frames, and lock is kept.
4. In VERIFY after 2 good commas, assert rx_disperr=2'b01 on one word → lock_state=HUNT, link_up=0, err_count unchanged.
   - Next 4 good commas are needed to lock.
5. Force err_count to 16'hFFFE, then inject 3 errors → holds at 16'hFFFF.
   - Then assert err_clr together with a 4th error → err_count=0, word_err=1.
6. Insert random rx_valid=0 gaps into a clean stream → lock timing counted in valid words only, no errors.
   - Assert rst_n=0 mid-LOCKED → all outputs 0 immediately; relock needs 25 words after release.
